// File: rtl/ddr_axi_port_arb.sv
// N-port round-robin front-end arbiter for the DDR controller's single AXI-like user port.
// Write (aw/w/b) and read (ar/r) paths arbitrate independently; a grant is held until burst end.
module ddr_axi_port_arb #(
    parameter int NUM_PORTS = 2,
    parameter int BA_BITS   = 2,
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 11,
    parameter int DQ_LEVEL  = 1,
    localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1,
    localparam int DW = 8 << DQ_LEVEL,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    core_clk,
    input  logic                    core_rstn_sync,
    input  logic [NUM_PORTS-1:0]    s_awvalid,
    output logic [NUM_PORTS-1:0]    s_awready,
    input  logic [NUM_PORTS*AW-1:0] s_awaddr,
    input  logic [NUM_PORTS*8-1:0]  s_awlen,
    input  logic [NUM_PORTS-1:0]    s_wvalid,
    output logic [NUM_PORTS-1:0]    s_wready,
    input  logic [NUM_PORTS-1:0]    s_wlast,
    input  logic [NUM_PORTS*DW-1:0] s_wdata,
    output logic [NUM_PORTS-1:0]    s_bvalid,
    input  logic [NUM_PORTS-1:0]    s_bready,
    input  logic [NUM_PORTS-1:0]    s_arvalid,
    output logic [NUM_PORTS-1:0]    s_arready,
    input  logic [NUM_PORTS*AW-1:0] s_araddr,
    input  logic [NUM_PORTS*8-1:0]  s_arlen,
    output logic [NUM_PORTS-1:0]    s_rvalid,
    input  logic [NUM_PORTS-1:0]    s_rready,
    output logic [NUM_PORTS-1:0]    s_rlast,
    output logic [NUM_PORTS*DW-1:0] s_rdata,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [AW-1:0]           m_awaddr,
    output logic [7:0]              m_awlen,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic                    m_wlast,
    output logic [DW-1:0]           m_wdata,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [AW-1:0]           m_araddr,
    output logic [7:0]              m_arlen,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic                    m_rlast,
    input  logic [DW-1:0]           m_rdata,
    output logic [PW-1:0]           wr_grant,
    output logic [PW-1:0]           rd_grant,
    output logic                    err_wlen,
    output logic                    err_rlen
);

    typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} wr_state_e;
    typedef enum logic [1:0] {RIdle, RAddr, RData}        rd_state_e;

    wr_state_e      wst_q, wst_d;
    rd_state_e      rst_q, rst_d;
    logic [PW-1:0]  wgnt_q, wgnt_d, rgnt_q, rgnt_d;
    logic [PW-1:0]  ptr_w_q, ptr_w_d, ptr_r_q, ptr_r_d;
    logic [7:0]     awlen_q, awlen_d, arlen_q, arlen_d;
    logic [8:0]     wbeat_q, wbeat_d, rbeat_q, rbeat_d;
    logic           err_wlen_q, err_wlen_d, err_rlen_q, err_rlen_d;
    logic [PW-1:0]  wpick, rpick;
    logic [8:0]     wlen_exp, rlen_exp;

    // First requester after ptr, wrapping; descending loop so the nearest one wins.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [PW-1:0] ptr);
        int idx;
        rr_pick = ptr;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (req[idx]) rr_pick = PW'(idx);
        end
    endfunction

    assign wpick    = rr_pick(s_awvalid, ptr_w_q);
    assign rpick    = rr_pick(s_arvalid, ptr_r_q);
    assign wlen_exp = {1'b0, awlen_q} + 9'd1;
    assign rlen_exp = {1'b0, arlen_q} + 9'd1;

    assign m_awaddr = s_awaddr[int'(wgnt_q)*AW +: AW];
    assign m_awlen  = s_awlen[int'(wgnt_q)*8 +: 8];
    assign m_wdata  = s_wdata[int'(wgnt_q)*DW +: DW];
    assign m_araddr = s_araddr[int'(rgnt_q)*AW +: AW];
    assign m_arlen  = s_arlen[int'(rgnt_q)*8 +: 8];
    assign s_rdata  = {NUM_PORTS{m_rdata}};

    assign wr_grant = wgnt_q;
    assign rd_grant = rgnt_q;
    assign err_wlen = err_wlen_q;
    assign err_rlen = err_rlen_q;

    always_comb begin
        wst_d      = wst_q;
        wgnt_d     = wgnt_q;
        ptr_w_d    = ptr_w_q;
        awlen_d    = awlen_q;
        wbeat_d    = wbeat_q;
        err_wlen_d = err_wlen_q;
        s_awready  = '0;
        s_wready   = '0;
        s_bvalid   = '0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_wlast    = 1'b0;
        m_bready   = 1'b0;
        unique case (wst_q)
            WIdle: begin
                if (|s_awvalid) begin
                    wgnt_d  = wpick;
                    awlen_d = s_awlen[int'(wpick)*8 +: 8];
                    wst_d   = WAddr;
                end
            end
            WAddr: begin
                m_awvalid         = s_awvalid[wgnt_q];
                s_awready[wgnt_q] = m_awready;
                if (s_awvalid[wgnt_q] && m_awready) begin
                    wbeat_d = '0;
                    wst_d   = WData;
                end
            end
            WData: begin
                m_wvalid         = s_wvalid[wgnt_q];
                m_wlast          = s_wlast[wgnt_q];
                s_wready[wgnt_q] = m_wready;
                if (s_wvalid[wgnt_q] && m_wready) begin
                    wbeat_d = wbeat_q + 9'd1;
                    if (s_wlast[wgnt_q]) begin
                        if (wbeat_q + 9'd1 != wlen_exp) err_wlen_d = 1'b1;
                        wst_d = WResp;
                    end else if (wbeat_q + 9'd1 == wlen_exp) begin
                        // Expected length reached with no wlast: burst is too long.
                        err_wlen_d = 1'b1;
                    end
                end
            end
            WResp: begin
                s_bvalid[wgnt_q] = m_bvalid;
                m_bready         = s_bready[wgnt_q];
                if (m_bvalid && s_bready[wgnt_q]) begin
                    ptr_w_d = wgnt_q;
                    wst_d   = WIdle;
                end
            end
            default: wst_d = WIdle;
        endcase
    end

    always_comb begin
        rst_d      = rst_q;
        rgnt_d     = rgnt_q;
        ptr_r_d    = ptr_r_q;
        arlen_d    = arlen_q;
        rbeat_d    = rbeat_q;
        err_rlen_d = err_rlen_q;
        s_arready  = '0;
        s_rvalid   = '0;
        s_rlast    = '0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        unique case (rst_q)
            RIdle: begin
                if (|s_arvalid) begin
                    rgnt_d  = rpick;
                    arlen_d = s_arlen[int'(rpick)*8 +: 8];
                    rst_d   = RAddr;
                end
            end
            RAddr: begin
                m_arvalid         = s_arvalid[rgnt_q];
                s_arready[rgnt_q] = m_arready;
                if (s_arvalid[rgnt_q] && m_arready) begin
                    rbeat_d = '0;
                    rst_d   = RData;
                end
            end
            RData: begin
                s_rvalid[rgnt_q] = m_rvalid;
                s_rlast[rgnt_q]  = m_rlast;
                m_rready         = s_rready[rgnt_q];
                if (m_rvalid && s_rready[rgnt_q]) begin
                    rbeat_d = rbeat_q + 9'd1;
                    if (m_rlast) begin
                        if (rbeat_q + 9'd1 != rlen_exp) err_rlen_d = 1'b1;
                        ptr_r_d = rgnt_q;
                        rst_d   = RIdle;
                    end
                end
            end
            default: rst_d = RIdle;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rstn_sync) begin
        if (!core_rstn_sync) begin
            wst_q      <= WIdle;
            rst_q      <= RIdle;
            wgnt_q     <= '0;
            rgnt_q     <= '0;
            ptr_w_q    <= PW'(NUM_PORTS - 1);
            ptr_r_q    <= PW'(NUM_PORTS - 1);
            awlen_q    <= '0;
            arlen_q    <= '0;
            wbeat_q    <= '0;
            rbeat_q    <= '0;
            err_wlen_q <= 1'b0;
            err_rlen_q <= 1'b0;
        end else begin
            wst_q      <= wst_d;
            rst_q      <= rst_d;
            wgnt_q     <= wgnt_d;
            rgnt_q     <= rgnt_d;
            ptr_w_q    <= ptr_w_d;
            ptr_r_q    <= ptr_r_d;
            awlen_q    <= awlen_d;
            arlen_q    <= arlen_d;
            wbeat_q    <= wbeat_d;
            rbeat_q    <= rbeat_d;
            err_wlen_q <= err_wlen_d;
            err_rlen_q <= err_rlen_d;
        end
    end

endmodule

// File: tb/tb_ddr_axi_port_arb.sv
// Directed self-checking bench for ddr_axi_port_arb (2 ports, 26-bit address, 16-bit data).
module tb_ddr_axi_port_arb;

    localparam int NP = 2;
    localparam int AW = 26;
    localparam int DW = 16;
    localparam int PW = 1;

    logic              core_clk = 1'b0;
    logic              core_rstn_sync;
    logic [NP-1:0]     s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [NP-1:0]     s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [NP*AW-1:0]  s_awaddr, s_araddr;
    logic [NP*8-1:0]   s_awlen, s_arlen;
    logic [NP*DW-1:0]  s_wdata, s_rdata;
    logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic              m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [AW-1:0]     m_awaddr, m_araddr;
    logic [7:0]        m_awlen, m_arlen;
    logic [DW-1:0]     m_wdata, m_rdata;
    logic [PW-1:0]     wr_grant, rd_grant;
    logic              err_wlen, err_rlen;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ddr_axi_port_arb #(.NUM_PORTS(NP)) dut (
        .core_clk(core_clk), .core_rstn_sync(core_rstn_sync),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast), .s_rdata(s_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
        .wr_grant(wr_grant), .rd_grant(rd_grant), .err_wlen(err_wlen), .err_rlen(err_rlen)
    );

    always #5 core_clk = ~core_clk;
    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int p, input int b);
        return DW'(32'hA000 + p * 256 + b);
    endfunction

    task automatic clear_inputs();
        s_awvalid = '0; s_awaddr = '0; s_awlen = '0;
        s_wvalid = '0; s_wlast = '0; s_wdata = '0; s_bready = '0;
        s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_rready = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset();
        core_rstn_sync = 1'b0;
        clear_inputs();
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        core_rstn_sync = 1'b1;
    endtask

    task automatic do_write(input int p, input logic [AW-1:0] addr, input logic [7:0] len,
                            input int nbeats);
        int  start;
        bit  ok;
        @(posedge core_clk); #1;
        start = cyc;
        s_awvalid[p] = 1'b1;
        s_awaddr[p*AW +: AW] = addr;
        s_awlen[p*8 +: 8] = len;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge core_clk);
            if (s_awready[p] && m_awvalid) begin ok = 1'b1; break; end
        end
        check("aw_handshake", 32'(ok), 1);
        check("aw_latency", cyc - start, 1);
        check("m_awaddr", 32'(m_awaddr), 32'(addr));
        check("m_awlen", 32'(m_awlen), 32'(len));
        check("wr_grant", 32'(wr_grant), p);
        @(posedge core_clk); #1;
        s_awvalid[p] = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            s_wvalid[p] = 1'b1;
            s_wdata[p*DW +: DW] = pat(p, b);
            s_wlast[p] = (b == nbeats - 1);
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge core_clk);
                if (s_wready[p] && m_wvalid) begin ok = 1'b1; break; end
            end
            check("w_handshake", 32'(ok), 1);
            check("m_wdata", 32'(m_wdata), 32'(pat(p, b)));
            check("m_wlast", 32'(m_wlast), 32'(b == nbeats - 1));
            check("w_other_ready", 32'(s_wready[1-p]), 0);
            @(posedge core_clk); #1;
        end
        s_wvalid[p] = 1'b0;
        s_wlast[p]  = 1'b0;
        m_bvalid    = 1'b1;
        s_bready[p] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge core_clk);
            if (s_bvalid[p] && m_bready) begin ok = 1'b1; break; end
        end
        check("b_handshake", 32'(ok), 1);
        check("b_other_valid", 32'(s_bvalid[1-p]), 0);
        @(posedge core_clk); #1;
        s_bready[p] = 1'b0;
        // Controller keeps bvalid up: the port must not see a second response.
        @(negedge core_clk);
        check("b_single_pulse", 32'(s_bvalid[p]), 0);
        m_bvalid = 1'b0;
    endtask

    task automatic do_read(input int p, input logic [AW-1:0] addr, input logic [7:0] len,
                           input int nbeats);
        int  start;
        bit  ok;
        @(posedge core_clk); #1;
        start = cyc;
        s_arvalid[p] = 1'b1;
        s_araddr[p*AW +: AW] = addr;
        s_arlen[p*8 +: 8] = len;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge core_clk);
            if (s_arready[p] && m_arvalid) begin ok = 1'b1; break; end
        end
        check("ar_handshake", 32'(ok), 1);
        check("ar_latency", cyc - start, 1);
        check("m_araddr", 32'(m_araddr), 32'(addr));
        check("m_arlen", 32'(m_arlen), 32'(len));
        check("rd_grant", 32'(rd_grant), p);
        @(posedge core_clk); #1;
        s_arvalid[p] = 1'b0;
        s_rready[p]  = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = pat(p + 4, b);
            m_rlast  = (b == nbeats - 1);
            @(negedge core_clk);
            check("s_rvalid", 32'(s_rvalid[p]), 1);
            check("s_rvalid_other", 32'(s_rvalid[1-p]), 0);
            check("s_rlast", 32'(s_rlast[p]), 32'(b == nbeats - 1));
            check("s_rdata", 32'(s_rdata[p*DW +: DW]), 32'(pat(p + 4, b)));
            check("m_rready", 32'(m_rready), 1);
            @(posedge core_clk); #1;
        end
        m_rlast = 1'b0;
        @(negedge core_clk);
        check("r_done_valid", 32'(s_rvalid[p]), 0);
        m_rvalid    = 1'b0;
        s_rready[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int        n;
        logic [PW-1:0] g [4];
        do_reset();

        check("rst_wr_grant", 32'(wr_grant), 0);
        check("rst_rd_grant", 32'(rd_grant), 0);
        check("rst_m_awvalid", 32'(m_awvalid), 0);
        check("rst_m_arvalid", 32'(m_arvalid), 0);
        check("rst_s_awready", 32'(s_awready), 0);
        check("rst_err_wlen", 32'(err_wlen), 0);
        check("rst_err_rlen", 32'(err_rlen), 0);

        // Basic 4-beat write from port 0.
        do_write(0, 26'h100, 8'd3, 4);
        check("wr_ok_err_wlen", 32'(err_wlen), 0);

        // Two ports contending continuously with single-beat bursts.
        do_reset();
        @(posedge core_clk); #1;
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_wlast = 2'b11; s_bready = 2'b11;
        s_awaddr[0 +: AW] = 26'h010; s_awaddr[AW +: AW] = 26'h020;
        m_bvalid = 1'b1;
        n = 0;
        for (int t = 0; t < 40 && n < 4; t++) begin
            @(negedge core_clk);
            if (m_awvalid) begin
                g[n] = wr_grant;
                check("rr_awaddr", 32'(m_awaddr), (wr_grant == 0) ? 32'h010 : 32'h020);
                check("rr_other_awready", 32'(s_awready[1-wr_grant]), 0);
                n++;
            end
        end
        check("rr_count", n, 4);
        check("rr_grant0", 32'(g[0]), 0);
        check("rr_grant1", 32'(g[1]), 1);
        check("rr_grant2", 32'(g[2]), 0);
        check("rr_grant3", 32'(g[3]), 1);
        check("rr_err_wlen", 32'(err_wlen), 0);

        // Parallel write (port 0) and read (port 1).
        do_reset();
        fork
            do_write(0, 26'h200, 8'd1, 2);
            do_read(1, 26'h340, 8'd7, 8);
        join
        check("par_err_wlen", 32'(err_wlen), 0);
        check("par_err_rlen", 32'(err_rlen), 0);

        // Short write: awlen=3, wlast on beat 2.
        check("pre_err_wlen", 32'(err_wlen), 0);
        do_write(0, 26'h080, 8'd3, 2);
        check("short_err_wlen", 32'(err_wlen), 1);
        // Next write starting with a 1-cycle grant proves the FSM went idle.
        do_write(1, 26'h090, 8'd0, 1);
        check("sticky_err_wlen", 32'(err_wlen), 1);

        // Controller rlast on beat 3 for arlen=1.
        do_read(0, 26'h0a0, 8'd1, 3);
        check("long_err_rlen", 32'(err_rlen), 1);

        // Reset during W_DATA beat 2.
        @(posedge core_clk); #1;
        s_awvalid[0] = 1'b1; s_awaddr[0 +: AW] = 26'h3c0; s_awlen[0 +: 8] = 8'd3;
        @(posedge core_clk); #1;
        @(posedge core_clk); #1;
        s_awvalid[0] = 1'b0;
        s_wvalid[0] = 1'b1; s_wdata[0 +: DW] = pat(0, 0);
        @(posedge core_clk); #1;
        s_wdata[0 +: DW] = pat(0, 1);
        @(negedge core_clk);
        check("mid_m_wvalid_pre", 32'(m_wvalid), 1);
        #2;
        core_rstn_sync = 1'b0;
        #1;
        check("async_m_wvalid", 32'(m_wvalid), 0);
        check("async_s_wready", 32'(s_wready), 0);
        check("async_m_awvalid", 32'(m_awvalid), 0);
        check("async_wr_grant", 32'(wr_grant), 0);
        check("async_err_wlen", 32'(err_wlen), 0);
        check("async_err_rlen", 32'(err_rlen), 0);
        clear_inputs();
        @(negedge core_clk);
        core_rstn_sync = 1'b1;
        do_write(0, 26'h3c0, 8'd3, 4);
        check("post_rst_err_wlen", 32'(err_wlen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_axi_port_arb.md
Name: ddr_axi_port_arb

Overview:
- N-port front-end arbiter placed in front of the DDR1 controller's single AXI-like user port.
- Independent round-robin arbitration for the write path (aw/w/b) and the read path (ar/r).
- A granted port owns its path until the burst completes: write through the b handshake, read through rlast.
- Runs in the controller core clock domain. Adds beat counting and sticky burst-length error flags.

Parameters:
- NUM_PORTS, 2, number of requestor ports (2..8).
- BA_BITS, 2, bank address bits.
- ROW_BITS, 13, row address bits.
- COL_BITS, 11, column address bits.
- DQ_LEVEL, 1, data width select; data width DW = 8<<DQ_LEVEL.
- Derived AW = BA_BITS+ROW_BITS+COL_BITS+DQ_LEVEL-1; PW = clog2(NUM_PORTS), minimum 1.

Ports:
- core_clk  in  1  controller core clock; all logic on its rising edge.
- core_rstn_sync  in  1  reset, asynchronous, active-low.
- s_awvalid  in  NUM_PORTS  per-port write address valid.
- s_awready  out  NUM_PORTS
- s_awaddr  in  NUM_PORTS*AW  port p at [p*AW +: AW].
- s_awlen  in  NUM_PORTS*8
- s_wvalid  in  NUM_PORTS
- s_wready  out  NUM_PORTS
- s_wlast  in  NUM_PORTS
- s_wdata  in  NUM_PORTS*DW
- s_bvalid  out  NUM_PORTS
- s_bready  in  NUM_PORTS
- s_arvalid  in  NUM_PORTS
- s_arready  out  NUM_PORTS
- s_araddr  in  NUM_PORTS*AW
- s_arlen  in  NUM_PORTS*8
- s_rvalid  out  NUM_PORTS
- s_rready  in  NUM_PORTS
- s_rlast  out  NUM_PORTS
- s_rdata  out  NUM_PORTS*DW  broadcast copy of m_rdata to all ports.
- m_awvalid/m_awready/m_awaddr/m_awlen, m_wvalid/m_wready/m_wlast/m_wdata, m_bvalid/m_bready, m_arvalid/m_arready/m_araddr/m_arlen, m_rvalid/m_rready/m_rlast/m_rdata  out/in mirrored  AW/8/DW as above  single master port to the controller.
- wr_grant  out  PW  current write owner.
- rd_grant  out  PW  current read owner.
- err_wlen  out  1  sticky; wlast position ≠ awlen+1.
- err_rlen  out  1  sticky; rlast position ≠ arlen+1.

Behaviour:
- Reset (async assert, low):
  - Both FSMs go to IDLE; all valid/ready outputs 0.
  - wr_grant and rd_grant = 0.
  - RR pointers = NUM_PORTS-1, so port 0 has first priority.
  - Beat counters 0; error flags 0.
  - Reset mid-burst abandons the transfer without completion; the controller is reset alongside.
- Write FSM W_IDLE→W_ADDR→W_DATA→W_RESP→W_IDLE:
  - W_IDLE: if any s_awvalid, select the first requesting port searching ptr+1, ptr+2, … modulo NUM_PORTS. Register wr_grant, latch awlen, go W_ADDR. Takes 1 cycle; no handshake occurs in W_IDLE.
  - W_ADDR:
    - m_awvalid = s_awvalid[g]; m_awaddr/m_awlen muxed from port g.
    - s_awready[g] = m_awready; other ports' awready = 0.
    - On handshake, clear wbeat, go W_DATA.
  - W_DATA:
    - m_w* muxed from g; s_wready[g] = m_wready; other ports get 0.
    - Each handshake increments wbeat (9-bit).
    - On the handshake with wlast: if wbeat+1 ≠ awlen+1, set err_wlen. Go W_RESP.
    - Reaching awlen+1 beats without wlast also sets err_wlen; data keeps flowing until wlast.
  - W_RESP: s_bvalid[g] = m_bvalid; m_bready = s_bready[g]. On handshake, ptr_w = g, go W_IDLE.
- Read FSM R_IDLE→R_ADDR→R_DATA→R_IDLE: same arbitration and addressing using the ar signals.
  - R_DATA: s_rvalid[g] = m_rvalid; s_rlast[g] = m_rlast; m_rready = s_rready[g].
  - rbeat counts handshakes. On the rlast handshake, compare against arlen+1 (mismatch sets err_rlen), set ptr_r = g, go R_IDLE.
- Read and write paths are fully independent; simultaneous aw and ar from the same or different ports proceed in parallel.
- A port withdrawing s_awvalid/s_arvalid in *_ADDR simply stalls that path; the grant is held, with no re-arbitration until the burst completes.
- Non-granted ports always see ready=0 and valid=0.
- A single requestor is re-granted back-to-back; the idle gap is 1 cycle between bursts.

Test Plan:
- Reset, then port 0 writes awaddr=0x100, awlen=3, 4 beats, wlast on beat 4 → m_awaddr=0x100, 4 m_w beats, s_bvalid[0] pulses once, err_wlen stays 0.
- Ports 0 and 1 assert awvalid together continuously, awlen=0 each → grants alternate 0,1,0,1; after the first write to port 0, port 1 is granted next.
- Port 1 reads arlen=7 while port 0 writes awlen=1 in the same cycle → both address handshakes complete in parallel; 8 r beats routed only to port 1 with s_rlast[1] on beat 8.
- Port 0 write with awlen=3 but wlast on beat 2 → err_wlen=1 from the next cycle and stays 1 after the burst; FSM returns to W_IDLE after the b handshake.
- Controller returns rlast on beat 3 for arlen=1 → err_rlen set.
- Reset asserted during W_DATA beat 2 → all outputs 0 asynchronously; after release, a new port-0 write completes normally.
